// File: rtl/prio_bit_scanner_if.sv
`default_nettype none
// ============================================================================
// Module      : prio_bit_scanner_if
// Description : Request/beat handshake bundle for prio_bit_scanner.
// Revision    : 1.0 - initial release
// ============================================================================
interface prio_bit_scanner_if #(
    parameter int IN_WIDTH  = 8,
    parameter int IDX_WIDTH = $clog2(IN_WIDTH),
    parameter int SEQ_WIDTH = $clog2(IN_WIDTH + 1)
);
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_vec;
    logic                 out_valid;
    logic                 out_ready;
    logic [IDX_WIDTH-1:0] out_idx;
    logic [SEQ_WIDTH-1:0] out_seq;
    logic                 out_last;
    logic                 out_none;

    // Scanner side
    modport slave (
        input  in_valid, in_vec, out_ready,
        output in_ready, out_valid, out_idx, out_seq, out_last, out_none
    );

    // Producer/consumer side
    modport master (
        output in_valid, in_vec, out_ready,
        input  in_ready, out_valid, out_idx, out_seq, out_last, out_none
    );
endinterface
`default_nettype wire

// File: rtl/prio_bit_scanner.sv
`default_nettype none
// ============================================================================
// Module      : prio_bit_scanner
// Description : Enumerates every set bit of an accepted request vector, one
//               index per beat, highest priority first. Define
//               PRIO_SCAN_LSB_FIRST_EN to enumerate lowest bit first instead.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_bit_scanner #(
    parameter int IN_WIDTH  = 8,
    parameter int IDX_WIDTH = $clog2(IN_WIDTH),
    parameter int SEQ_WIDTH = $clog2(IN_WIDTH + 1)
) (
    input  wire logic          clk,
    input  wire logic          rst,
    prio_bit_scanner_if.slave  bus
);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_SCAN = 1'b1
    } state_t;

    state_t               r_state;
    state_t               w_state_nxt;
    logic [IN_WIDTH-1:0]  r_pending;
    logic [IN_WIDTH-1:0]  w_pending_nxt;
    logic                 r_zero;
    logic                 w_zero_nxt;
    logic [SEQ_WIDTH-1:0] r_seq;
    logic [SEQ_WIDTH-1:0] w_seq_nxt;

    logic [IDX_WIDTH-1:0] w_idx;
    logic                 w_scan;
    logic                 w_last;
    logic                 w_in_ready;
    logic                 w_accept;

    // Later loop iterations override earlier ones, so the iteration order
    // decides which set bit wins.
    always_comb begin
        w_idx = '0;
`ifdef PRIO_SCAN_LSB_FIRST_EN
        for (int i = IN_WIDTH - 1; i >= 0; i--) begin
            if (r_pending[i]) w_idx = IDX_WIDTH'(i);
        end
`else
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (r_pending[i]) w_idx = IDX_WIDTH'(i);
        end
`endif
    end

    assign w_scan     = (r_state == S_SCAN);
    // At most one bit left (or the zero-vector marker) means final beat.
    assign w_last     = w_scan &
                        (r_zero | ((r_pending & (r_pending - IN_WIDTH'(1))) == '0));
    assign w_in_ready = ~w_scan | (w_last & bus.out_ready);
    assign w_accept   = bus.in_valid & w_in_ready;

    always_comb begin
        w_state_nxt   = r_state;
        w_pending_nxt = r_pending;
        w_zero_nxt    = r_zero;
        w_seq_nxt     = r_seq;
        if (w_accept) begin
            w_state_nxt   = S_SCAN;
            w_pending_nxt = bus.in_vec;
            w_zero_nxt    = (bus.in_vec == '0);
            w_seq_nxt     = '0;
        end else if (w_scan && bus.out_ready) begin
            if (!w_last) begin
                w_pending_nxt[w_idx] = 1'b0;
                w_seq_nxt            = r_seq + SEQ_WIDTH'(1);
            end else begin
                w_state_nxt   = S_IDLE;
                w_pending_nxt = '0;
                w_zero_nxt    = 1'b0;
                w_seq_nxt     = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pending <= '0;
            r_zero    <= 1'b0;
            r_seq     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_pending <= w_pending_nxt;
            r_zero    <= w_zero_nxt;
            r_seq     <= w_seq_nxt;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_scan;
    assign bus.out_idx   = (w_scan && !r_zero) ? w_idx : '0;
    assign bus.out_seq   = w_scan ? r_seq : '0;
    assign bus.out_last  = w_last;
    assign bus.out_none  = w_scan & r_zero;

endmodule
`default_nettype wire
